// File: rtl/weight_mem_if_nn_pkg.sv
// Shared definitions for the weight-memory fetch interface: lane count, FSM
// states and the mapping from a MAC lane index to its slice of w_out.
package weight_mem_if_nn_pkg;

  localparam int NUM_MAC    = 4;
  localparam int LANE_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } wmif_state_e;

  // Lane k occupies w_out[k*DATA_W +: DATA_W], so mac0 sits in the LSBs.
  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/weight_mem_if_nn_if.sv
// Handshake and memory-bus bundle for weight_mem_if_nn. The slave modport is
// the fetch block; the master modport is the controller/memory side.
interface weight_mem_if_nn_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  import weight_mem_if_nn_pkg::*;

  logic                        load_req;
  logic [ADDR_W-1:0]           base_addr;
  logic                        mem_rd_en;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_rd_data;
  logic [NUM_MAC*DATA_W-1:0]   w_out;
  logic                        load_ready;
  logic                        busy;

  modport slave (
    input  load_req, base_addr, mem_rd_data,
    output mem_rd_en, mem_addr, w_out, load_ready, busy
  );

  modport master (
    output load_req, base_addr, mem_rd_data,
    input  mem_rd_en, mem_addr, w_out, load_ready, busy
  );

endinterface

// File: rtl/weight_mem_if_nn_lat_pipe.sv
// Valid/lane-index delay line matching the weight memory read latency, so each
// returning word is tagged with the lane it belongs to.
module wmif_lat_pipe #(
  parameter int MEM_LAT = 1,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic             vld_q [MEM_LAT];
  logic [IDX_W-1:0] idx_q [MEM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[MEM_LAT-1];
  assign out_idx = idx_q[MEM_LAT-1];

endmodule

// File: rtl/weight_mem_if_nn.sv
// Fetches NUM_MAC consecutive weight words and commits them atomically to w_out.
// Optional sticky req_err output for ignored load requests: WMIF_REQ_ERR_EN.
//
// state | meaning
// IDLE  | no weights committed since reset, waiting for load_req
// FETCH | issuing the four reads, one per cycle
// DRAIN | reads done, waiting for the last word to return
// READY | w_out stable and complete, load_ready high
module weight_mem_if_nn
  import weight_mem_if_nn_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  weight_mem_if_nn_if.slave   bus
`ifdef WMIF_REQ_ERR_EN
  ,
  output logic                req_err
`endif
);

  wmif_state_e               state_q, state_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [LANE_IDX_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic                      done_q, done_d;
  logic                      commit;
  logic [DATA_W-1:0]         stage_q [NUM_MAC];
  logic [NUM_MAC*DATA_W-1:0] w_out_q;
  logic                      pipe_vld;
  logic [LANE_IDX_W-1:0]     pipe_idx;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    rd_cnt_d   = rd_cnt_q;
    done_d     = done_q;
    commit     = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (bus.load_req) begin
          state_d    = FETCH;
          mem_addr_d = bus.base_addr;
          rd_cnt_d   = '0;
          done_d     = 1'b0;
        end
      end
      FETCH: begin
        // mem_addr stops on the last read address so it holds once reads end.
        if (rd_cnt_q == LANE_IDX_W'(NUM_MAC-1)) begin
          state_d = DRAIN;
        end else begin
          rd_cnt_d   = rd_cnt_q + LANE_IDX_W'(1);
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (done_q) begin
          state_d = READY;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pipe_vld && (pipe_idx == LANE_IDX_W'(NUM_MAC-1))) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      rd_cnt_q   <= '0;
      done_q     <= 1'b0;
      w_out_q    <= '0;
      for (int i = 0; i < NUM_MAC; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      done_q     <= done_d;
      if (pipe_vld) begin
        stage_q[pipe_idx] <= bus.mem_rd_data;
      end
      if (commit) begin
        for (int i = 0; i < NUM_MAC; i++) begin
          w_out_q[lane_lsb(i, DATA_W) +: DATA_W] <= stage_q[i];
        end
      end
    end
  end

  wmif_lat_pipe #(
    .MEM_LAT (MEM_LAT),
    .IDX_W   (LANE_IDX_W)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (state_q == FETCH),
    .in_idx  (rd_cnt_q),
    .out_vld (pipe_vld),
    .out_idx (pipe_idx)
  );

  assign bus.mem_rd_en  = (state_q == FETCH);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.w_out      = w_out_q;
  assign bus.load_ready = (state_q == READY);
  assign bus.busy       = (state_q == FETCH) || (state_q == DRAIN);

`ifdef WMIF_REQ_ERR_EN
  logic req_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_err_q <= 1'b0;
    end else if (bus.load_req && ((state_q == FETCH) || (state_q == DRAIN))) begin
      req_err_q <= 1'b1;
    end
  end

  assign req_err = req_err_q;
`endif

endmodule

// File: tb/tb_weight_mem_if_nn.sv
// Directed + randomized bench for weight_mem_if_nn with MEM_LAT=1 and MEM_LAT=3
// instances, checked against a transaction-level model of each weight load.
module tb_weight_mem_if_nn;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  weight_mem_if_nn_if #(.DATA_W(8), .ADDR_W(8)) b0 ();
  weight_mem_if_nn_if #(.DATA_W(8), .ADDR_W(8)) b1 ();

`ifdef WMIF_REQ_ERR_EN
  logic req_err0, req_err1;
`endif

  weight_mem_if_nn #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(1)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
`ifdef WMIF_REQ_ERR_EN
    ,
    .req_err (req_err0)
`endif
  );

  weight_mem_if_nn #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(3)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
`ifdef WMIF_REQ_ERR_EN
    ,
    .req_err (req_err1)
`endif
  );

  // Weight memories: data for the sampled address appears MEM_LAT cycles later.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] p0;
  logic [7:0] p1 [3];

  always @(posedge clk) p0 <= mem0[b0.mem_addr];
  always @(posedge clk) begin
    p1[0] <= mem1[b1.mem_addr];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign b0.mem_rd_data = p0;
  assign b1.mem_rd_data = p1[2];

  logic [31:0] exp_w0, exp_w1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_w(input int sel, input logic [7:0] base);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = (sel == 1) ? mem1[8'(base + 8'(k))] : mem0[8'(base + 8'(k))];
    return w;
  endfunction

  task automatic set_req(input int sel, input logic v, input logic [7:0] b);
    if (sel == 1) begin
      b1.load_req = v; b1.base_addr = b;
    end else begin
      b0.load_req = v; b0.base_addr = b;
    end
  endtask

  task automatic fill(input int sel, input logic [7:0] base, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      if (sel == 1) mem1[8'(base + 8'(k))] = w[8*k +: 8];
      else          mem0[8'(base + 8'(k))] = w[8*k +: 8];
  endtask

  // One load transaction; inject_at >= 0 issues a second load_req at that cycle.
  task automatic load_and_check(input int sel, input logic [7:0] base, input int inject_at,
                                input string tag);
    int lat, lat_exp, nrd, rises, bad_hold, bad_busy, bad_addr;
    logic [31:0] w_prev, w_new, w;
    logic rdy, rdy_prev, en, bsy;
    logic [7:0] a;
    lat_exp = 4 + ((sel == 1) ? 3 : 1) + 1;
    w_prev  = (sel == 1) ? exp_w1 : exp_w0;
    w_new   = model_w(sel, base);
    lat = -1; nrd = 0; rises = 0; bad_hold = 0; bad_busy = 0; bad_addr = 0;
    rdy_prev = 1'b0;
    @(negedge clk);
    set_req(sel, 1'b1, base);
    @(posedge clk);
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      set_req(sel, c == inject_at, base ^ 8'h5A);
      en  = (sel == 1) ? b1.mem_rd_en  : b0.mem_rd_en;
      a   = (sel == 1) ? b1.mem_addr   : b0.mem_addr;
      w   = (sel == 1) ? b1.w_out      : b0.w_out;
      rdy = (sel == 1) ? b1.load_ready : b0.load_ready;
      bsy = (sel == 1) ? b1.busy       : b0.busy;
      if (c == 0) chk({tag, "_ready_drop"}, 64'(rdy), 64'(0));
      if (en) begin
        if (c != nrd || a !== 8'(base + 8'(nrd))) bad_addr++;
        nrd++;
      end else if (nrd == 4 && a !== 8'(base + 8'd3)) begin
        bad_addr++;
      end
      if (rdy && !rdy_prev) rises++;
      if (rdy) lat = c;
      else begin
        if (w !== w_prev) bad_hold++;
        if (!bsy) bad_busy++;
      end
      rdy_prev = rdy;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_reads"}, 64'(nrd), 64'(4));
    chk({tag, "_addr_seq"}, 64'(bad_addr), 64'(0));
    chk({tag, "_w_hold"}, 64'(bad_hold), 64'(0));
    chk({tag, "_busy"}, 64'(bad_busy), 64'(0));
    chk({tag, "_ready_rise"}, 64'(rises), 64'(1));
    chk({tag, "_w_out"}, 64'((sel == 1) ? b1.w_out : b0.w_out), 64'(w_new));
    chk({tag, "_busy_ready"}, 64'((sel == 1) ? b1.busy : b0.busy), 64'(0));
    if (sel == 1) exp_w1 = w_new; else exp_w0 = w_new;
  endtask

  task automatic hold_ready(input int sel, input int n, input string tag);
    int drops, changes;
    logic [31:0] w_exp;
    drops = 0; changes = 0;
    w_exp = (sel == 1) ? exp_w1 : exp_w0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (((sel == 1) ? b1.load_ready : b0.load_ready) !== 1'b1) drops++;
      if (((sel == 1) ? b1.w_out : b0.w_out) !== w_exp) changes++;
    end
    chk({tag, "_ready_held"}, 64'(drops), 64'(0));
    chk({tag, "_w_stable"}, 64'(changes), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base;
    int sel;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    exp_w0 = '0; exp_w1 = '0;
    rst = 1'b1;
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    // Reset must win over a simultaneous load request.
    @(negedge clk);
    set_req(0, 1'b1, 8'h10);
    @(negedge clk);
    set_req(0, 1'b0, 8'h10);
    chk("rst_busy0", 64'(b0.busy), 64'(0));
    chk("rst_ready0", 64'(b0.load_ready), 64'(0));
    chk("rst_rd_en0", 64'(b0.mem_rd_en), 64'(0));
    chk("rst_addr0", 64'(b0.mem_addr), 64'(0));
    chk("rst_w0", 64'(b0.w_out), 64'(0));
    chk("rst_busy1", 64'(b1.busy), 64'(0));
    chk("rst_w1", 64'(b1.w_out), 64'(0));
`ifdef WMIF_REQ_ERR_EN
    chk("rst_req_err", 64'(req_err0), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy0", 64'(b0.busy), 64'(0));

    fill(0, 8'h10, 32'h44332211);
    load_and_check(0, 8'h10, -1, "basic_lat1");
    chk("basic_lat1_const", 64'(b0.w_out), 64'(32'h44332211));

    load_and_check(1, 8'hFE, -1, "wrap_lat3");

    load_and_check(0, 8'h20, 1, "ignored_req");
`ifdef WMIF_REQ_ERR_EN
    chk("req_err_set", 64'(req_err0), 64'(1));
`endif

    load_and_check(0, 8'h10, -1, "reload_a");
    fill(0, 8'h40, 32'hA3A2A1A0);
    load_and_check(0, 8'h40, -1, "reload_b");
    chk("reload_b_const", 64'(b0.w_out), 64'(32'hA3A2A1A0));
`ifdef WMIF_REQ_ERR_EN
    chk("req_err_sticky", 64'(req_err0), 64'(1));
`endif
    hold_ready(0, 20, "handshake");

    // Reset in DRAIN on the MEM_LAT=3 instance, with words still in flight.
    @(negedge clk);
    set_req(1, 1'b1, 8'h80);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_req(1, 1'b0, 8'h80);
    end
    @(negedge clk);
    chk("drain_busy", 64'(b1.busy), 64'(1));
    chk("drain_rd_en", 64'(b1.mem_rd_en), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_w0 = '0; exp_w1 = '0;
    chk("mid_rst_busy", 64'(b1.busy), 64'(0));
    chk("mid_rst_ready", 64'(b1.load_ready), 64'(0));
    chk("mid_rst_w", 64'(b1.w_out), 64'(0));
`ifdef WMIF_REQ_ERR_EN
    chk("mid_rst_req_err", 64'(req_err0), 64'(0));
`endif
    repeat (6) @(negedge clk);
    chk("late_data_w", 64'(b1.w_out), 64'(0));
    chk("late_data_ready", 64'(b1.load_ready), 64'(0));
    load_and_check(1, 8'h80, -1, "after_rst");

    for (int i = 0; i < 8; i++) begin
      sel  = int'($urandom_range(0, 1));
      base = 8'($urandom);
      fill(sel, base, $urandom);
      load_and_check(sel, base, -1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
